operand_fetch: RTL and testbench



---
 rtl/operand_fetch_if.sv | 32 +++
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Issue, ALU-operand and write-back signal bundle for the operand-fetch stage.
// The master side drives issue requests and write-backs; the slave side is the stage itself.
interface operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] out_rd;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, rs1, rs2, rd, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, op_a, op_b, out_rd
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, op_a, op_b, out_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file with busy scoreboard, same-cycle write-back
// bypass, and one registered operand slot presented to the ALUs over valid/ready.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;

    logic              vld_p1;
    logic [DATA_W-1:0] op_a_p1;
    logic [DATA_W-1:0] op_b_p1;
    logic [ADDR_W-1:0] rd_p1;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              hz_a;
    logic              hz_b;
    logic              hz_d;
    logic              ready;
    logic              accept;
    logic              wb_live;

    // Index 0 reads as zero; a write-back landing this cycle is forwarded.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [ADDR_W-1:0] r,
        input logic [DATA_W-1:0] arr_val,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (r == '0)
            return '0;
        if (we && (wa == r))
            return wd;
        return arr_val;
    endfunction

    function automatic logic hazard(
        input logic              is_busy,
        input logic [ADDR_W-1:0] r,
        input logic              we,
        input logic [ADDR_W-1:0] wa
    );
        return (r != '0) && is_busy && !(we && (wa == r));
    endfunction

    assign wb_live = bus.wb_en && (bus.wb_addr != '0);

    assign src_a = bypass(bus.rs1, regs[bus.rs1], bus.wb_en, bus.wb_addr, bus.wb_data);
    assign src_b = bypass(bus.rs2, regs[bus.rs2], bus.wb_en, bus.wb_addr, bus.wb_data);

    assign hz_a = hazard(busy[bus.rs1], bus.rs1, bus.wb_en, bus.wb_addr);
    assign hz_b = hazard(busy[bus.rs2], bus.rs2, bus.wb_en, bus.wb_addr);
    assign hz_d = hazard(busy[bus.rd],  bus.rd,  bus.wb_en, bus.wb_addr);

    assign ready  = !rst && (!vld_p1 || bus.out_ready) && !hz_a && !hz_b && !hz_d;
    assign accept = bus.in_valid && ready;

    // Stage p1: architectural state update and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            rd_p1   <= '0;
            busy    <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (wb_live) begin
                regs[bus.wb_addr] <= bus.wb_data;
                busy[bus.wb_addr] <= 1'b0;
            end
            // Placed after the clear so a same-index set wins.
            if (accept) begin
                op_a_p1 <= src_a;
                op_b_p1 <= src_b;
                rd_p1   <= bus.rd;
                vld_p1  <= 1'b1;
                if (bus.rd != '0)
                    busy[bus.rd] <= 1'b1;
            end else if (vld_p1 && bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = vld_p1;
    assign bus.op_a      = op_a_p1;
    assign bus.op_b      = op_b_p1;
    assign bus.out_rd    = rd_p1;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural scoreboard model.
module tb_operand_fetch;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clk;
    logic rst;

    operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_pass;

    // Reference state: what the outputs must look like after the next edge.
    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    bit          m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_rd;
    bit          model_live;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_hz(int r);
        return (r != 0) && m_busy[r] && !(bus.wb_en && int'(bus.wb_addr) == r);
    endfunction

    function automatic logic [31:0] m_src(int r);
        if (r == 0) return 32'h0;
        if (bus.wb_en && int'(bus.wb_addr) == r) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_ready();
        return !rst && (!m_valid || bus.out_ready)
               && !m_hz(int'(bus.rs1)) && !m_hz(int'(bus.rs2)) && !m_hz(int'(bus.rd));
    endfunction

    // Compare process: check at the falling edge, then advance the model.
    initial begin
        bit          acc;
        logic [31:0] na;
        logic [31:0] nb;
        model_live = 0;
        forever begin
            @(negedge clk);
            if (model_live) begin
                check("in_ready",  32'(bus.in_ready),  32'(m_ready()));
                check("out_valid", 32'(bus.out_valid), 32'(m_valid));
                check("op_a",      bus.op_a,           m_a);
                check("op_b",      bus.op_b,           m_b);
                check("out_rd",    32'(bus.out_rd),    32'(m_rd));
            end
            if (rst) begin
                for (int i = 0; i < NREG; i++) begin
                    m_regs[i] = 32'h0;
                    m_busy[i] = 0;
                end
                m_valid = 0; m_a = 0; m_b = 0; m_rd = 0;
                model_live = 1;
            end else if (model_live) begin
                acc = bus.in_valid && m_ready();
                na  = m_src(int'(bus.rs1));
                nb  = m_src(int'(bus.rs2));
                if (bus.wb_en && bus.wb_addr != 0) begin
                    m_regs[bus.wb_addr] = bus.wb_data;
                    m_busy[bus.wb_addr] = 0;
                end
                if (acc) begin
                    m_a = na; m_b = nb; m_rd = int'(bus.rd); m_valid = 1;
                    if (bus.rd != 0) m_busy[bus.rd] = 1;
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input int a, input int b, input int d);
        bus.in_valid = v;
        bus.rs1 = 5'(a);
        bus.rs2 = 5'(b);
        bus.rd  = 5'(d);
    endtask

    task automatic wb(input bit en, input int addr, input logic [31:0] data);
        bus.wb_en   = en;
        bus.wb_addr = 5'(addr);
        bus.wb_data = data;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        issue(0, 0, 0, 0);
        wb(0, 0, 32'h0);

        // Reset held two cycles, then a read of an untouched register.
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        issue(1, 3, 0, 0);
        tick();
        issue(0, 0, 0, 0);
        check("first_valid", 32'(bus.out_valid), 32'h1);
        check("first_op_a", bus.op_a, 32'h0);
        check("first_op_b", bus.op_b, 32'h0);

        // Bypassed read, then the same read from the array.
        wb(1, 5, 32'hDEADBEEF);
        issue(1, 5, 5, 0);
        tick();
        wb(0, 0, 32'h0);
        check("byp_op_a", bus.op_a, 32'hDEADBEEF);
        check("byp_op_b", bus.op_b, 32'hDEADBEEF);
        tick();
        issue(0, 0, 0, 0);
        check("arr_op_a", bus.op_a, 32'hDEADBEEF);
        check("arr_op_b", bus.op_b, 32'hDEADBEEF);

        // RAW stall released by the clearing write-back in the same cycle.
        issue(1, 0, 0, 7);
        tick();
        issue(1, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2 check("raw_stall", 32'(bus.in_ready), 32'h0);
            tick();
        end
        wb(1, 7, 32'h1234);
        #2 check("raw_release", 32'(bus.in_ready), 32'h1);
        tick();
        wb(0, 0, 32'h0);
        issue(0, 0, 0, 0);
        check("raw_op_a", bus.op_a, 32'h1234);

        // Back-pressure: held operands ignore a write-back during the stall.
        issue(1, 5, 5, 11);
        tick();
        bus.out_ready = 1'b0;
        issue(1, 3, 0, 0);
        wb(1, 5, 32'h55555555);
        for (int i = 0; i < 3; i++) begin
            #2 check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            tick();
            wb(0, 0, 32'h0);
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_op_a", bus.op_a, 32'hDEADBEEF);
            check("bp_op_b", bus.op_b, 32'hDEADBEEF);
            check("bp_out_rd", 32'(bus.out_rd), 32'd11);
        end
        bus.out_ready = 1'b1;
        #2 check("bp_release", 32'(bus.in_ready), 32'h1);
        tick();
        issue(0, 0, 0, 0);
        check("bp_next_valid", 32'(bus.out_valid), 32'h1);
        check("bp_next_op_a", bus.op_a, 32'h0);

        // Register 0 ignores writes and never creates a hazard.
        wb(1, 0, 32'hFFFFFFFF);
        issue(1, 0, 0, 0);
        tick();
        wb(0, 0, 32'h0);
        check("x0_bypass", bus.op_a, 32'h0);
        issue(1, 0, 0, 0);
        tick();
        check("x0_read", bus.op_a, 32'h0);
        #2 check("x0_no_stall", 32'(bus.in_ready), 32'h1);
        tick();
        issue(0, 0, 0, 0);

        // Set/clear collision keeps the register busy; reset clears everything.
        issue(1, 0, 0, 9);
        tick();
        wb(1, 9, 32'h99);
        #2 check("coll_accept", 32'(bus.in_ready), 32'h1);
        tick();
        wb(0, 0, 32'h0);
        issue(1, 9, 0, 0);
        #2 check("coll_still_busy", 32'(bus.in_ready), 32'h0);
        check("coll_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        issue(0, 0, 0, 0);
        wb(1, 4, 32'hABCD);
        tick();
        rst = 1'b0;
        wb(0, 0, 32'h0);
        check("rst_mid_valid", 32'(bus.out_valid), 32'h0);
        issue(1, 9, 5, 0);
        #2 check("rst_busy_clear", 32'(bus.in_ready), 32'h1);
        tick();
        issue(1, 4, 0, 0);
        check("rst_regs_a", bus.op_a, 32'h0);
        check("rst_regs_b", bus.op_b, 32'h0);
        tick();
        issue(0, 0, 0, 0);
        check("rst_wb_dropped", bus.op_a, 32'h0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.rs1       = 5'($urandom_range(0, 7));
            bus.rs2       = 5'($urandom_range(0, 7));
            bus.rd        = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_en     = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        issue(0, 0, 0, 0);
        wb(0, 0, 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
